// File: rtl/spi_slave_burst_fe.sv
// SPI-clock-domain front end of the SPI register port.
// Decodes R/W + address frames, optional auto-increment bursts, and a programmable
// read turnaround. Transfers leave over a toggle req/ack handshake.
module spi_slave_burst_fe #(
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned DUMMY_CYCLES = 4,
  parameter bit          BURST_EN     = 1'b1
) (
  input  logic              spi_clk,
  input  logic              sys_rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              req_tgl,
  output logic              req_wr,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              ack_tgl,
  input  logic [DATA_W-1:0] ack_rdata,
  output logic              err_ovr,
  output logic              err_late
);

  localparam int unsigned CNT_MAX0 = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > DUMMY_CYCLES) ? CNT_MAX0 : DUMMY_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CYCLES - 1);

  // IDLE also covers the command bit: edge 1 latches R/W and moves straight to ADDR.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_DUMMY = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic              oe_q, oe_d;

  logic              ack_meta_q, ack_s_q;
  logic              outstanding;
  logic              frame_rst_n;

  logic              issue, issue_wr, load;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;

  // Frame state is cleared by either system reset or a deselected chip select.
  assign frame_rst_n = sys_rst_n & ~spi_cs_n;
  assign outstanding = (req_tgl != ack_s_q);
  assign spi_miso    = oe_q & sr_q[DATA_W-1];
  assign spi_miso_oe = oe_q;

  // Frame decoder: next state, shift registers and transfer issue/load strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    sr_d        = sr_q;
    oe_d        = oe_q;
    issue       = 1'b0;
    issue_wr    = 1'b0;
    issue_addr  = addr_q;
    issue_wdata = sr_q;
    load        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rd_d    = spi_mosi;
        cnt_d   = '0;
        state_d = ST_ADDR;
      end
      ST_ADDR: begin
        addr_d = {addr_q[ADDR_W-2:0], spi_mosi};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == ADDR_LAST) begin
          cnt_d = '0;
          if (rd_q) begin
            issue      = 1'b1;
            issue_addr = addr_d;
            state_d    = ST_DUMMY;
          end else begin
            state_d = ST_WDATA;
          end
        end
      end
      ST_WDATA: begin
        sr_d  = {sr_q[DATA_W-2:0], spi_mosi};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DATA_LAST) begin
          cnt_d       = '0;
          issue       = 1'b1;
          issue_wr    = 1'b1;
          issue_addr  = addr_q;
          issue_wdata = sr_d;
          if (BURST_EN) begin
            addr_d = addr_q + 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DUMMY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DUMMY_LAST) begin
          load = 1'b1;
        end
      end
      ST_RDATA: begin
        sr_d  = {sr_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DATA_LAST) begin
          if (BURST_EN) begin
            load = 1'b1;
          end else begin
            cnt_d   = '0;
            oe_d    = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      default: ;
    endcase
    // Load edge: an unacked read yields zeros; in burst mode prefetch the next address.
    if (load) begin
      sr_d    = outstanding ? '0 : ack_rdata;
      oe_d    = 1'b1;
      cnt_d   = '0;
      state_d = ST_RDATA;
      if (BURST_EN) begin
        issue      = 1'b1;
        issue_addr = addr_q + 1'b1;
        addr_d     = addr_q + 1'b1;
      end
    end
  end

  // Frame registers.
  always_ff @(posedge spi_clk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      sr_q    <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      sr_q    <= sr_d;
      oe_q    <= oe_d;
    end
  end

  // Two-flop synchroniser for the system-domain ack toggle.
  always_ff @(posedge spi_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= ack_tgl;
      ack_s_q    <= ack_meta_q;
    end
  end

  // Request port and sticky error flags; survive chip-select deassertion.
  always_ff @(posedge spi_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      req_tgl   <= 1'b0;
      req_wr    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      err_ovr   <= 1'b0;
      err_late  <= 1'b0;
    end else begin
      if (issue) begin
        if (outstanding) begin
          err_ovr <= 1'b1;
        end else begin
          req_tgl  <= ~req_tgl;
          req_wr   <= issue_wr;
          req_addr <= issue_addr;
          if (issue_wr) begin
            req_wdata <= issue_wdata;
          end
        end
      end
      if (load && outstanding) begin
        err_late <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_burst_fe.sv
// Randomised and directed bench for spi_slave_burst_fe with a frame-level reference model.
module tb_spi_slave_burst_fe;
  localparam int A  = 15;
  localparam int D  = 16;
  localparam int DC = 4;

  logic        spi_clk = 1'b0;
  logic        sys_rst_n, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe, req_tgl, req_wr;
  logic [14:0] req_addr;
  logic [15:0] req_wdata;
  logic        ack_tgl;
  logic [15:0] ack_rdata;
  logic        err_ovr, err_late;

  always #5 spi_clk = ~spi_clk;

  spi_slave_burst_fe #(
    .ADDR_W(15), .DATA_W(16), .DUMMY_CYCLES(4), .BURST_EN(1'b1)
  ) dut (
    .spi_clk    (spi_clk),
    .sys_rst_n  (sys_rst_n),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .req_tgl    (req_tgl),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .ack_tgl    (ack_tgl),
    .ack_rdata  (ack_rdata),
    .err_ovr    (err_ovr),
    .err_late   (err_late)
  );

  int n_vec = 0;
  int n_err = 0;

  // Contents of the system-side register space as seen by reads.
  function automatic logic [15:0] sysdata(input logic [14:0] a);
    return {1'b0, a} ^ 16'hA5D3;
  endfunction

  // ---------------- reference model ----------------
  logic        m_req_tgl, m_req_wr, m_ovr, m_late, m_oe, m_rw, m_a1, m_a2;
  logic [14:0] m_req_addr, m_addr;
  logic [15:0] m_req_wdata, m_word, m_wsh;
  int          m_n, m_ld;

  task automatic model_clear();
    m_req_tgl = 0; m_req_wr = 0; m_req_addr = '0; m_req_wdata = '0;
    m_ovr = 0; m_late = 0; m_oe = 0; m_rw = 0; m_a1 = 0; m_a2 = 0;
    m_addr = '0; m_word = '0; m_wsh = '0; m_n = 0; m_ld = 0;
  endtask

  task automatic model_issue(input logic outst, input logic wr, input logic [14:0] a,
                             input logic [15:0] wd);
    if (outst) m_ovr = 1'b1;
    else begin
      m_req_tgl = ~m_req_tgl;
      m_req_wr  = wr;
      m_req_addr = a;
      if (wr) m_req_wdata = wd;
    end
  endtask

  // One rising edge, in terms of the edge number within the frame.
  task automatic model_edge();
    logic outst;
    int   k;
    if (!sys_rst_n) begin
      model_clear();
      return;
    end
    // The DUT sees ack_tgl two edges late.
    outst = (m_req_tgl != m_a2);
    if (spi_cs_n) begin
      m_n  = 0;
      m_oe = 0;
    end else begin
      m_n++;
      if (m_n == 1) begin
        m_rw   = spi_mosi;
        m_addr = '0;
      end else if (m_n <= A + 1) begin
        m_addr = {m_addr[13:0], spi_mosi};
      end
      if (m_rw) begin
        if (m_n == A + 1) model_issue(outst, 1'b0, m_addr, 16'h0);
        else if (m_n >= A + 1 + DC && (m_n - A - 1 - DC) % D == 0) begin
          k = (m_n - A - 1 - DC) / D;
          if (outst) begin
            m_word = '0;
            m_late = 1'b1;
          end else begin
            m_word = sysdata(m_req_addr);
          end
          m_oe = 1'b1;
          m_ld = m_n;
          model_issue(outst, 1'b0, m_addr + 15'(k + 1), 16'h0);
        end
      end else if (m_n > A + 1) begin
        m_wsh = {m_wsh[14:0], spi_mosi};
        if ((m_n - A - 1) % D == 0) begin
          k = (m_n - A - 1) / D;
          model_issue(outst, 1'b1, m_addr + 15'(k - 1), m_wsh);
        end
      end
    end
    m_a2 = m_a1;
    m_a1 = ack_tgl;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int   idx;
    logic em;
    idx = m_n - m_ld;
    em  = (m_oe && idx >= 0 && idx < D) ? m_word[D-1-idx] : 1'b0;
    chk("req_tgl", 32'(req_tgl), 32'(m_req_tgl));
    chk("req_wr", 32'(req_wr), 32'(m_req_wr));
    chk("req_addr", 32'(req_addr), 32'(m_req_addr));
    chk("req_wdata", 32'(req_wdata), 32'(m_req_wdata));
    chk("err_ovr", 32'(err_ovr), 32'(m_ovr));
    chk("err_late", 32'(err_late), 32'(m_late));
    chk("spi_miso_oe", 32'(spi_miso_oe), 32'(m_oe));
    chk("spi_miso", 32'(spi_miso), 32'(em));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_miso"}, 32'(spi_miso), 0);
    chk({nm, "_oe"}, 32'(spi_miso_oe), 0);
    chk({nm, "_req_tgl"}, 32'(req_tgl), 0);
    chk({nm, "_req_wr"}, 32'(req_wr), 0);
    chk({nm, "_req_addr"}, 32'(req_addr), 0);
    chk({nm, "_req_wdata"}, 32'(req_wdata), 0);
    chk({nm, "_err_ovr"}, 32'(err_ovr), 0);
    chk({nm, "_err_late"}, 32'(err_late), 0);
  endtask

  // ---------------- system-side ack responder ----------------
  int   ack_delay = 1;
  bit   ack_en = 1;
  int   ack_cnt = 0;
  logic seen = 0;

  task automatic responder();
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        ack_tgl   = ~ack_tgl;
        ack_rdata = sysdata(req_addr);
      end
    end
    if (req_tgl !== seen) begin
      seen = req_tgl;
      if (ack_en) ack_cnt = ack_delay;
    end
  endtask

  // ---------------- stimulus ----------------
  int   fe = 0;
  logic last_req = 0;
  int   flip_e[$];
  int   flip_a[$];
  logic miso_log[128];
  int   first_oe, first_ovr;
  bit   fq[$];

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic cs, input logic b);
    spi_cs_n = cs;
    spi_mosi = b;
    fe = cs ? 0 : fe + 1;
    responder();
    @(posedge spi_clk);
    model_edge();
    #1;
    compare_all();
    if (req_tgl !== last_req) begin
      last_req = req_tgl;
      flip_e.push_back(fe);
      flip_a.push_back(int'(req_addr));
    end
    if (fe > 0 && fe < 128) miso_log[fe] = spi_miso;
    if (first_oe == 0 && spi_miso_oe) first_oe = fe;
    if (first_ovr == 0 && err_ovr) first_ovr = fe;
    @(negedge spi_clk);
  endtask

  task automatic do_reset();
    sys_rst_n = 0;
    spi_cs_n  = 1;
    ack_tgl   = 0;
    ack_cnt   = 0;
    seen      = 0;
    last_req  = 0;
    model_clear();
    #1;
    chk_all_zero("reset");
    @(negedge spi_clk);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    sys_rst_n = 1;
    step(1'b1, 1'b0);
  endtask

  task automatic fq_header(input bit rw, input logic [14:0] a);
    fq.delete();
    fq.push_back(rw);
    for (int i = 14; i >= 0; i--) fq.push_back(a[i]);
  endtask

  task automatic fq_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) fq.push_back(w[i]);
  endtask

  task automatic fq_rand(input int n);
    for (int i = 0; i < n; i++) fq.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic run_frame(input int gap);
    flip_e.delete();
    flip_a.delete();
    first_oe  = 0;
    first_ovr = 0;
    foreach (fq[i]) step(1'b0, fq[i]);
    for (int i = 0; i < gap; i++) step(1'b1, 1'($urandom_range(0, 1)));
  endtask

  function automatic logic [15:0] miso_word(input int start);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) w = {w[14:0], miso_log[start + i]};
    return w;
  endfunction

  initial begin
    logic [14:0] ra;
    int          len;
    sys_rst_n = 0; spi_cs_n = 1; spi_mosi = 0; ack_tgl = 0; ack_rdata = '0;
    model_clear();
    @(negedge spi_clk);
    do_reset();

    // Single write.
    fq_header(1'b0, 15'h1234); fq_word(16'hBEEF); run_frame(3);
    chk("t1_nflips", flip_e.size(), 1);
    chk("t1_flip_edge", flip_e[0], 32);
    chk("t1_req_wr", 32'(req_wr), 1);
    chk("t1_req_addr", 32'(req_addr), 32'h1234);
    chk("t1_req_wdata", 32'(req_wdata), 32'hBEEF);

    // Burst write across the address wrap.
    fq_header(1'b0, 15'h7FFE); fq_word(16'h0101); fq_word(16'h0202); fq_word(16'h0303);
    run_frame(3);
    chk("t2_nflips", flip_e.size(), 3);
    chk("t2_e0", flip_e[0], 32); chk("t2_e1", flip_e[1], 48); chk("t2_e2", flip_e[2], 64);
    chk("t2_a0", flip_a[0], 32'h7FFE); chk("t2_a1", flip_a[1], 32'h7FFF);
    chk("t2_a2", flip_a[2], 32'h0000);
    chk("t2_err_ovr", 32'(err_ovr), 0);

    // Read with prompt ack.
    fq_header(1'b1, 15'h0010); fq_rand(20); run_frame(3);
    chk("t3_flip_edge", flip_e[0], 16);
    chk("t3_first_oe", first_oe, 20);
    chk("t3_miso_word", 32'(miso_word(20)), 32'hA5C3);
    chk("t3_err_late", 32'(err_late), 0);

    // Read with a late ack.
    ack_delay = 10;
    fq_header(1'b1, 15'h0020); fq_rand(20); run_frame(3);
    chk("t4_miso_word", 32'(miso_word(20)), 0);
    chk("t4_err_late", 32'(err_late), 1);
    ack_delay = 1;
    do_reset();

    // Burst write with the system not acking.
    ack_en = 0;
    fq_header(1'b0, 15'h0100); fq_word(16'h1111); fq_word(16'h2222); fq_word(16'h3333);
    run_frame(3);
    chk("t5_nflips", flip_e.size(), 1);
    chk("t5_flip_edge", flip_e[0], 32);
    chk("t5_first_ovr", first_ovr, 48);
    chk("t5_req_wdata", 32'(req_wdata), 32'h1111);
    ack_en = 1;
    do_reset();

    // Aborted frame then a clean write.
    fq_header(1'b0, 15'h5555); while (fq.size() > 8) void'(fq.pop_back()); run_frame(2);
    fq_header(1'b0, 15'h0ABC); fq_word(16'h5A5A); run_frame(3);
    chk("t6_nflips", flip_e.size(), 1);
    chk("t6_flip_edge", flip_e[0], 32);
    chk("t6_req_addr", 32'(req_addr), 32'h0ABC);
    chk("t6_req_wdata", 32'(req_wdata), 32'h5A5A);

    // Randomised frames.
    for (int f = 0; f < 40; f++) begin
      ra = ($urandom_range(0, 3) == 0) ? 15'(15'h7FFC + 15'($urandom_range(0, 3)))
                                       : 15'($urandom);
      ack_delay = $urandom_range(1, 12);
      len = $urandom_range(1, 90);
      fq_header(1'($urandom_range(0, 1)), ra);
      fq_rand(100);
      while (fq.size() > len) void'(fq.pop_back());
      run_frame($urandom_range(1, 4));
    end
    ack_delay = 1;

    // Reset in the middle of a read word.
    fq_header(1'b1, 15'h0300); fq_rand(10);
    foreach (fq[i]) step(1'b0, fq[i]);
    chk("t7_oe_before", 32'(spi_miso_oe), 1);
    #2;
    do_reset();
    fq_header(1'b0, 15'h0042); fq_word(16'hC001); run_frame(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
